// File: rtl/led_io_ctrl.sv
// led_io_ctrl: memory-mapped LED output peripheral.
// Captures chip-selected IO writes into four 16-bit register slots, drives
// the 17 board LEDs from them, and returns register contents combinationally
// on IO reads so the single-cycle CPU load path sees the data in the same cycle.
//
// Register map (addr[2:1] selects, addr[0] ignored):
//   0x0 LED_LO  led[15:0] value
//   0x2 LED_HI  bit0 -> led[16]
//   0x4 BLINK   per-bit blink mask for led[15:0]
//   0x6 CTRL    bit0 EN (output enable), bit1 BLK (blink run)
//
// Build option: define LED_BLINK_EN to implement the blink engine, the BLINK
// register and CTRL.BLK. Without it the phase is a constant "on", BLINK and
// BLK read as 0 and ignore writes, and no counter logic exists.
module led_io_ctrl #(
   parameter int unsigned BLINK_DIV = 25_000_000
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        led_cs,
   input  logic        iowrite,
   input  logic        ioread,
   input  logic [2:0]  addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic [16:0] led
);

   localparam logic [1:0] SEL_LED_LO = 2'd0;
   localparam logic [1:0] SEL_LED_HI = 2'd1;
   localparam logic [1:0] SEL_BLINK  = 2'd2;
   localparam logic [1:0] SEL_CTRL   = 2'd3;

   logic        w_wr;
   logic        w_rd;
   logic [1:0]  w_sel;
   logic [15:0] w_blink_mask;
   logic        w_blk;
   logic        w_phase;
   logic        w_unused;

   logic [15:0] r_led_lo;
   logic        r_led_hi;
   logic        r_en;

   assign w_wr  = led_cs & iowrite;
   assign w_rd  = led_cs & ioread;
   assign w_sel = addr[2:1];

   // addr[0] is a byte-offset bit the register file does not decode.
   assign w_unused = ^{addr[0], 32'(BLINK_DIV)};

   // Always-present registers: LED value, LED[16] and the global enable.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_led_lo <= 16'h0000;
         r_led_hi <= 1'b0;
         r_en     <= 1'b1;
      end else if (w_wr) begin
         case (w_sel)
            SEL_LED_LO: r_led_lo <= wdata;
            SEL_LED_HI: r_led_hi <= wdata[0];
            SEL_CTRL:   r_en     <= wdata[0];
            default:    ;
         endcase
      end
   end

`ifdef LED_BLINK_EN
   localparam logic [31:0] LP_CNT_TC = 32'(BLINK_DIV - 1);

   logic [15:0] r_blink;
   logic        r_blk;
   logic [31:0] r_cnt;
   logic        r_phase;
   logic        w_restart;

   // A write to CTRL or BLINK restarts the pattern in the on phase.
   assign w_restart = w_wr & ((w_sel == SEL_CTRL) | (w_sel == SEL_BLINK));

   // Blink mask and blink-run bit.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_blink <= 16'h0000;
         r_blk   <= 1'b0;
      end else if (w_wr) begin
         case (w_sel)
            SEL_BLINK: r_blink <= wdata;
            SEL_CTRL:  r_blk   <= wdata[1];
            default:   ;
         endcase
      end
   end

   // Prescaler: counts 0..BLINK_DIV-1 while running, toggling phase on wrap.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_cnt   <= 32'd0;
         r_phase <= 1'b1;
      end else if (w_restart || !r_blk) begin
         r_cnt   <= 32'd0;
         r_phase <= 1'b1;
      end else if (r_cnt == LP_CNT_TC) begin
         r_cnt   <= 32'd0;
         r_phase <= ~r_phase;
      end else begin
         r_cnt   <= r_cnt + 32'd1;
      end
   end

   assign w_blink_mask = r_blink;
   assign w_blk        = r_blk;
   assign w_phase      = r_phase;
`else
   assign w_blink_mask = 16'h0000;
   assign w_blk        = 1'b0;
   assign w_phase      = 1'b1;
`endif

   // Readback mux; zero unless a qualified read strobe is present.
   always_comb begin
      rdata = 16'h0000;
      if (w_rd) begin
         case (w_sel)
            SEL_LED_LO: rdata = r_led_lo;
            SEL_LED_HI: rdata = {15'h0000, r_led_hi};
            SEL_BLINK:  rdata = w_blink_mask;
            SEL_CTRL:   rdata = {14'h0000, w_blk, r_en};
            default:    rdata = 16'h0000;
         endcase
      end
   end

   // LED drive: blinked bits are forced off during the off phase; led[16] never blinks.
   always_comb begin
      led[15:0] = r_en ? (r_led_lo & ~(w_blink_mask & {16{~w_phase}})) : 16'h0000;
      led[16]   = r_en & r_led_hi;
   end

endmodule

// File: doc/led_io_ctrl.md
# led_io_ctrl

Memory-mapped LED output peripheral; the write-side responder for CPU I/O stores decoded by the memory/IO address decoder. It captures `sw`-mapped IO writes when the LED chip-select is active, holds LED state in registers, supports per-bit hardware blinking from a free-running prescaler, and returns register contents on IO reads. It sits between the decoder's `LEDCtrl`/`iowrite`/`write_data` outputs and the board `led[16:0]` pins.

## Interface

Parameters:
- `BLINK_DIV`, default 25_000_000: `sys_clk` cycles per blink half-period; legal range is 1 to 2^32-1.

Ports:
- `sys_clk`  in  1  system clock; all state updates occur on the rising edge.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `led_cs`  in  1  LED chip-select from the address decoder.
- `iowrite`  in  1  IO write strobe, qualified by `led_cs`.
- `ioread`  in  1  IO read strobe, qualified by `led_cs`.
- `addr`  in  3  byte offset; `addr[2:1]` selects the register and `addr[0]` is ignored.
- `wdata`  in  16  write data.
- `rdata`  out  16  readback data; combinational from the registers.
- `led`  out  17  board LEDs.

## Operation

Registers (offset: name, reset value):
- 0x0 `LED_LO`: `led[15:0]` value, reset 0x0000.
- 0x2 `LED_HI`: bit0 drives `led[16]`, reset 0. Bits 15:1 read as 0.
- 0x4 `BLINK`: per-bit blink mask for `led[15:0]`, reset 0x0000.
- 0x6 `CTRL`: bit0 `EN` (global output enable), reset 1; bit1 `BLK` (blink run), reset 0. Bits 15:2 read as 0.

Register access:
- Write: a write occurs when `led_cs & iowrite` at a rising edge. It updates the selected register with `wdata`, masked to its implemented bits.
- Read: when `led_cs & ioread` is asserted, `rdata` equals the selected register. Otherwise `rdata` is 0x0000.

Blink engine:
- State is a 32-bit counter `cnt` and a `phase` bit. Reset values are `cnt = 0` and `phase = 1` (on).
- When `BLK = 1`, `cnt` increments every cycle. When `cnt == BLINK_DIV-1`, `cnt` wraps to 0 and `phase` toggles.
- When `BLK = 0`, `cnt` is held at 0 and `phase` is held at 1.
- Any write to `CTRL` or `BLINK` forces `cnt = 0` and `phase = 1` on that edge, overriding the normal increment. A new pattern therefore always starts in the on phase.

Output equation:
- `led[15:0] = EN ? (LED_LO & ~(BLINK & {16{~phase}})) : 0`
- `led[16] = EN & LED_HI[0]`, which is never blinked.

Boundary conditions:
- Simultaneous read and write to the same register: `rdata` shows the pre-edge value, and the write takes effect at the edge.
- `led_cs = 0` with strobes asserted: no register changes and `rdata = 0`.
- With `BLINK_DIV = 1`, `phase` toggles every cycle while `BLK = 1`.
- Reset asserted mid-blink: all registers, `cnt` and `phase` return to their reset values immediately and asynchronously. `led` becomes 0 because `LED_LO` is cleared.

## Timing

- Write latency: `led` reflects a register write in the cycle after the write edge, because `led` is combinational from the registers.
- Read latency: zero cycles; combinational in the same cycle. This is required by the single-cycle CPU load path.
- Blink period: 2*`BLINK_DIV` cycles per full on/off period. The first off-phase begins `BLINK_DIV` cycles after the `CTRL`/`BLINK` write edge.
- No handshake or back-pressure: every qualified strobe completes in one cycle.

## Configuration

- `LED_BLINK_EN` defined: the blink engine, the `BLINK` register and `CTRL.BLK` are implemented as described above.
- `LED_BLINK_EN` undefined:
  - No counter or `phase` logic is synthesised, and `phase` is treated as constant 1.
  - `BLINK` and `CTRL.BLK` read as 0, and writes to them are ignored.
  - `CTRL.EN` remains functional.

## Test plan

The bench uses `BLINK_DIV = 4`.

1. Reset release: `led = 0`, `rdata = 0`, and reading `CTRL` returns 0x0001.
2. Write 0xA5A5 to 0x0 and 1 to 0x2: the next cycle `led = 17'h1A5A5`. Reading 0x0 returns 0xA5A5 and reading 0x2 returns 0x0001.
3. Set `LED_LO = 0xFFFF`, write `BLINK = 0x00FF`, then `CTRL = 0x0003`: `led[15:0]` is 0xFFFF for 4 cycles, 0xFF00 for 4 cycles, then 0xFFFF again, with the pattern repeating.
4. Write with `led_cs = 0` and `iowrite = 1`, `wdata = 0x1234` to 0x0: `LED_LO` is unchanged and `rdata = 0`.
5. Write `CTRL = 0x0000`: `led = 0` next cycle while `LED_LO` retains its value. Writing `CTRL = 0x0001` restores the previous `led` value.
6. Assert `sys_rst_n = 0` while blinking in the off phase: `led = 0`, `cnt = 0` and `phase = 1` immediately, without waiting for a clock edge.
